// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } dmem_arb_state_t;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_AUX  = 1'b1;

    function automatic logic [1:0] port_onehot(input logic idx);
        port_onehot = (idx == PORT_AUX) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/arb_picker.sv
// Combinational two-way picker. DMEM_ARB_ROUND_ROBIN_EN selects round-robin
// tie-breaking; otherwise port 0 (core) always wins ties.
module arb_picker
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic [1:0] gnt
);

    logic unused_last_s;
    assign unused_last_s = last_owner;

    // Pick one requester; ties resolved by the selected policy
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                if (last_owner == PORT_CORE) begin
                    gnt = port_onehot(PORT_AUX);
                end else begin
                    gnt = port_onehot(PORT_CORE);
                end
`else
                gnt = port_onehot(PORT_CORE);
`endif
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single data-memory port.
// Optional round-robin tie-break enabled by DMEM_ARB_ROUND_ROBIN_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             req,
    input  logic [1:0]             we,
    input  logic [1:0][ADDR_W-1:0] addr,
    input  logic [1:0][DATA_W-1:0] wdata,
    input  logic [1:0][2:0]        funct3,
    output logic [1:0]             gnt,
    output logic [1:0]             done,
    output logic [DATA_W-1:0]      rdata,
    output logic                   busy,
    output logic                   mem_wren,
    output logic [ADDR_W-1:0]      mem_address,
    output logic [DATA_W-1:0]      mem_data_in,
    output logic [2:0]             mem_funct3,
    input  logic [DATA_W-1:0]      mem_data_out
);

    localparam int CNT_W = $clog2(READ_LATENCY + 1);

    dmem_arb_state_t state_r, next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic             owner_r;
    logic             we_r;
    logic [1:0]       pick_s;
    logic             win_s;
    logic             last_s;
    logic             accept_s;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic rr_last_r;

    // Remember the most recent winner; reset value lets port 0 win first
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_last_r <= PORT_AUX;
        end else if (accept_s) begin
            rr_last_r <= win_s;
        end else begin
            rr_last_r <= rr_last_r;
        end
    end
    assign last_s = rr_last_r;
`else
    assign last_s = PORT_CORE;
`endif

    arb_picker u_picker (
        .req        (req),
        .last_owner (last_s),
        .gnt        (pick_s)
    );

    assign win_s    = pick_s[1];
    assign accept_s = (state_r == IDLE) && (|req);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; grant is only issued from IDLE
    always_comb begin
        next_state_s = state_r;
        gnt          = 2'b00;
        case (state_r)
            IDLE: begin
                if (|req) begin
                    gnt          = pick_s;
                    next_state_s = ISSUE;
                end else begin
                    gnt          = 2'b00;
                    next_state_s = IDLE;
                end
            end
            ISSUE: begin
                if (we_r) begin
                    next_state_s = RESP;
                end else begin
                    next_state_s = WAIT;
                end
            end
            WAIT: begin
                if (cnt_r == CNT_W'(1)) begin
                    next_state_s = RESP;
                end else begin
                    next_state_s = WAIT;
                end
            end
            RESP:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Latch the winner's request and drive the memory port from it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_r     <= PORT_CORE;
            we_r        <= 1'b0;
            mem_wren    <= 1'b0;
            mem_address <= {ADDR_W{1'b0}};
            mem_data_in <= {DATA_W{1'b0}};
            mem_funct3  <= 3'b000;
        end else begin
            mem_wren <= accept_s & we[win_s];
            if (accept_s) begin
                owner_r     <= win_s;
                we_r        <= we[win_s];
                mem_address <= addr[win_s];
                mem_data_in <= wdata[win_s];
                mem_funct3  <= funct3[win_s];
            end
        end
    end

    // Read-latency counter, load data capture and status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= {CNT_W{1'b0}};
            rdata <= {DATA_W{1'b0}};
            done  <= 2'b00;
            busy  <= 1'b0;
        end else begin
            busy <= (next_state_s != IDLE);
            done <= (next_state_s == RESP) ? port_onehot(owner_r) : 2'b00;
            if (state_r == ISSUE) begin
                cnt_r <= CNT_W'(READ_LATENCY);
            end else if (state_r == WAIT) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if ((state_r == WAIT) && (cnt_r == CNT_W'(1))) begin
                rdata <= mem_data_out;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised self-checking bench for dmem_arbiter with a transaction-level model.
module tb_dmem_arbiter;

    localparam int RL = 3;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic [1:0] req, we, gnt, done;
    logic [1:0][AW-1:0] addr;
    logic [1:0][DW-1:0] wdata;
    logic [1:0][2:0] funct3;
    logic [DW-1:0] rdata, mem_data_in, mem_data_out;
    logic [AW-1:0] mem_address;
    logic busy, mem_wren;
    logic [2:0] mem_funct3;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .funct3(funct3), .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
        .mem_wren(mem_wren), .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_funct3(mem_funct3), .mem_data_out(mem_data_out)
    );

    function automatic logic [31:0] init_val(input int i);
        return (i == 4) ? 32'hDEAD_BEEF : 32'h1357_0000 + 32'(i) * 32'h0001_0111;
    endfunction

    // Memory environment: synchronous read with RL latency, data only valid exactly RL cycles after issue
    logic [DW-1:0] env_mem [16];
    logic [AW-1:0] ap [RL];
    logic          vp [RL];
    logic          busy_q;
    logic [DW-1:0] noise;
    always @(posedge clk) begin
        noise <= $urandom;
        if (!reset) begin
            for (int i = 0; i < RL; i++) begin vp[i] <= 1'b0; ap[i] <= 32'h0; end
            busy_q <= 1'b0;
            for (int i = 0; i < 16; i++) env_mem[i] <= init_val(i);
        end else begin
            for (int i = RL - 1; i > 0; i--) begin ap[i] <= ap[i-1]; vp[i] <= vp[i-1]; end
            ap[0]  <= mem_address;
            vp[0]  <= busy & ~busy_q;
            busy_q <= busy;
            if (mem_wren) env_mem[mem_address[5:2]] <= mem_data_in;
        end
    end
    assign mem_data_out = vp[RL-1] ? env_mem[ap[RL-1][5:2]] : noise;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    function automatic void chk(input string name, input logic [31:0] a, input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, a, e, cyc);
        end
    endfunction

    // Transaction-level model: a grant at cycle t0 fixes every output for cycles t0..t0+len-1
    logic [1:0]  eg, ed;
    logic        eb, ew;
    logic [31:0] ema, emd, erd;
    logic [2:0]  ef3;
    logic [31:0] mmem [16];
    bit          act, o_we, owner, last;
    int          t0, len, k;
    logic [31:0] o_addr, o_wd;
    logic [2:0]  o_f3;

    initial begin
        act = 1'b0; last = 1'b1; eg = 2'b00;
        forever begin
            @(negedge clk);
            eg = 2'b00; ed = 2'b00; eb = 1'b0; ew = 1'b0;
            if (!reset) begin
                act = 1'b0; last = 1'b1;
                ema = 32'h0; emd = 32'h0; ef3 = 3'b000; erd = 32'h0;
                for (int i = 0; i < 16; i++) mmem[i] = init_val(i);
            end else if (!act) begin
                if (req != 2'b00) begin
                    if (req == 2'b11) owner = RR_EN ? ~last : 1'b0;
                    else owner = req[1];
                    eg = owner ? 2'b10 : 2'b01;
                    last = owner; act = 1'b1; t0 = cyc;
                    o_we = we[owner]; o_addr = addr[owner]; o_wd = wdata[owner]; o_f3 = funct3[owner];
                    len = o_we ? 3 : 3 + RL;
                end
            end else begin
                eb = 1'b1;
                k = cyc - t0;
                if (k == 1) begin
                    ema = o_addr; emd = o_wd; ef3 = o_f3; ew = o_we;
                    if (o_we) mmem[o_addr[5:2]] = o_wd;
                end
                if (k == len - 1) begin
                    ed = owner ? 2'b10 : 2'b01;
                    if (!o_we) erd = mmem[o_addr[5:2]];
                    act = 1'b0;
                end
            end
            chk("gnt", 32'(gnt), 32'(eg));
            chk("done", 32'(done), 32'(ed));
            chk("busy", 32'(busy), 32'(eb));
            chk("mem_wren", 32'(mem_wren), 32'(ew));
            chk("mem_address", mem_address, ema);
            chk("mem_data_in", mem_data_in, emd);
            chk("mem_funct3", 32'(mem_funct3), 32'(ef3));
            chk("rdata", rdata, erd);
            cyc++;
        end
    end

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic look(); @(negedge clk); #1; endtask

    logic [1:0] gseq [4];
    logic [1:0] gexp [4];
    int n;

    initial begin
        reset = 1'b0; req = 2'b00; we = 2'b00; addr = '0; wdata = '0; funct3 = '0;
        for (int i = 0; i < 4; i++) gexp[i] = (RR_EN && (i % 2 == 1)) ? 2'b10 : 2'b01;
        repeat (3) tick();
        look();
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_address", mem_address, 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        tick(); reset = 1'b1;

        // Port 0 load from 0x10, memory holds 0xDEADBEEF
        tick(); req = 2'b01; we = 2'b00; addr[0] = 32'h10; wdata[0] = 32'h0BAD_F00D; funct3[0] = 3'b010;
        look(); chk("ld_gnt", 32'(gnt), 32'h1);
        tick(); req = 2'b00; addr[0] = 32'hFFFF_FFF0;
        look(); chk("ld_addr_issue", mem_address, 32'h10); chk("ld_wren", 32'(mem_wren), 32'h0);
        for (int i = 0; i < RL; i++) begin
            tick(); look();
            chk("ld_addr_wait", mem_address, 32'h10);
            chk("ld_done_early", 32'(done), 32'h0);
        end
        tick(); look(); chk("ld_done", 32'(done), 32'h1); chk("ld_rdata", rdata, 32'hDEAD_BEEF);
        tick(); look(); chk("ld_idle_busy", 32'(busy), 32'h0);

        // Port 1 store of 0x12345678 to 0x20
        tick(); req = 2'b10; we = 2'b10; addr[1] = 32'h20; wdata[1] = 32'h1234_5678; funct3[1] = 3'b010;
        look(); chk("st_gnt", 32'(gnt), 32'h2);
        tick(); req = 2'b00; we = 2'b00; wdata[1] = 32'h0;
        look();
        chk("st_wren", 32'(mem_wren), 32'h1);
        chk("st_mem_data_in", mem_data_in, 32'h1234_5678);
        chk("st_mem_funct3", 32'(mem_funct3), 32'h2);
        chk("st_mem_address", mem_address, 32'h20);
        tick(); look(); chk("st_wren_off", 32'(mem_wren), 32'h0); chk("st_done", 32'(done), 32'h2);
        chk("st_rdata_kept", rdata, 32'hDEAD_BEEF);

        // Both ports requesting continuously
        tick(); req = 2'b11; we = 2'b11; addr[0] = 32'h30; addr[1] = 32'h34;
        wdata[0] = $urandom; wdata[1] = $urandom;
        n = 0;
        for (int c = 0; c < 16 && n < 4; c++) begin
            look();
            if (gnt != 2'b00) begin gseq[n] = gnt; n++; end
            tick();
        end
        req = 2'b00; we = 2'b00;
        chk("tie_count", 32'(n), 32'd4);
        for (int i = 0; i < 4; i++) chk("tie_seq", 32'(gseq[i]), 32'(gexp[i]));
        repeat (4) tick();

        // Port 1 requests during a port 0 load
        req = 2'b01; we = 2'b00; addr[0] = 32'h44;
        look(); chk("ho_gnt0", 32'(gnt), 32'h1);
        tick(); req = 2'b10; we = 2'b00; addr[1] = 32'h48;
        for (int j = 1; j <= 2 + RL; j++) begin
            look();
            chk("ho_gnt1_held", 32'(gnt), 32'h0);
            if (j == 2 + RL) chk("ho_done0", 32'(done), 32'h1);
            tick();
        end
        look(); chk("ho_gnt1", 32'(gnt), 32'h2);
        tick(); req = 2'b00;
        repeat (RL + 3) tick();

        // Reset pulsed low during WAIT
        req = 2'b01; we = 2'b00; addr[0] = 32'h50;
        look(); chk("rw_gnt", 32'(gnt), 32'h1);
        tick(); req = 2'b00;
        tick(); look(); chk("rw_busy", 32'(busy), 32'h1);
        tick(); reset = 1'b0; #1;
        chk("rw_busy0", 32'(busy), 32'h0);
        chk("rw_mem_address0", mem_address, 32'h0);
        chk("rw_rdata0", rdata, 32'h0);
        chk("rw_done0", 32'(done), 32'h0);
        chk("rw_mem_data_in0", mem_data_in, 32'h0);
        tick(); reset = 1'b1;
        for (int j = 0; j < RL + 2; j++) begin look(); chk("rw_no_done", 32'(done), 32'h0); tick(); end
        req = 2'b10; we = 2'b00; addr[1] = 32'h54;
        look(); chk("rw_regnt", 32'(gnt), 32'h2);
        tick(); req = 2'b00;

        // Randomised traffic; a granted requester drops or re-randomises its request
        for (int c = 0; c < 1500; c++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (req[p] && eg[p]) req[p] = 1'b0;
                if (!req[p]) begin
                    we[p] = 1'($urandom_range(0, 1));
                    addr[p] = $urandom;
                    wdata[p] = $urandom;
                    funct3[p] = 3'($urandom_range(0, 7));
                    if ($urandom_range(0, 99) < 45) req[p] = 1'b1;
                end
            end
        end
        req = 2'b00;
        repeat (RL + 5) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
